mcs_bridge_seq: RTL
===================

// Module: mcs_bridge_seq
// PURPOSE
//  Registered, multi-slot successor to the combinational MCS bridge. Sits between the MicroBlaze MCS
//  I/O bus and N_CS FPro slave regions (mmio, video, ...); decodes, registers and times each access.
//  Supports fixed read latency or slave-driven fp_ready stall with timeout, and byte enables.
//  Reports sticky error flags for unmapped, timed-out and overrun accesses.
// PARAMETERS
//  BRG_BASE  32'hc000_0000  bridge window; hit when io_address[31:24]==BRG_BASE[31:24]
//  N_CS      2              slave regions; index = io_address[23 -: CS_W], CS_W=max(1,$clog2(N_CS))
//  ADDR_W    21             fp_addr width = io_address[ADDR_W+1:2]; ADDR_W+2+CS_W<=24 required
//  RD_LAT    1              fixed mode: cycles from ISSUE to fp_rd_data valid (1..15)
//  USE_RDY   0              1: completion by fp_ready; 0: fixed timing (fp_ready ignored)
//  TIMEOUT   16             USE_RDY=1: cycles in ISSUE/WAIT before forced completion (2..255)
// PORTS
//  clk             in   1       system clock
//  reset_n         in   1       async active-low reset
//  io_address      in   32      MCS byte address
//  io_addr_strobe  in   1       1-cycle transaction start
//  io_write_data   in   32      write data
//  io_write_strobe in   1       write qualifier (with addr strobe)
//  io_byte_enable  in   4       byte lanes
//  io_read_strobe  in   1       read qualifier (with addr strobe)
//  io_read_data    out  32      registered read data, valid with io_ready
//  io_ready        out  1       1-cycle completion pulse
//  fp_cs           out  N_CS    one-hot slot select
//  fp_wr / fp_rd   out  1       write / read request
//  fp_addr         out  ADDR_W  word address
//  fp_wr_data      out  32      write data
//  fp_be           out  4       byte enables
//  fp_rd_data      in   32      slave read data
//  fp_ready        in   1       slave done (USE_RDY=1 only)
//  err_clr         in   1       clears all sticky errors
//  err_unmapped    out  1       sticky: access outside window or index>=N_CS
//  err_timeout     out  1       sticky: USE_RDY timeout
//  err_overrun     out  1       sticky: strobe while busy
//  busy            out  1       FSM not IDLE
// BEHAVIOUR
//  Reset: FSM=IDLE; all outputs 0 (io_read_data=0, fp_cs=0, errs=0); mid-transaction reset aborts silently.
//  FSM IDLE->ISSUE->WAIT->RESP->IDLE; all fp_* and io_* outputs registered.
//  IDLE: on io_addr_strobe with exactly one of wr/rd strobes: latch addr/data/be/dir.
//    Hit & index<N_CS -> ISSUE. Miss, bad index, or both/neither strobes -> RESP, data 0, err_unmapped<=1.
//  ISSUE: fp_cs[idx]=1, fp_wr or fp_rd=1, fp_addr/fp_wr_data/fp_be stable; held through WAIT.
//  Fixed mode: write: 1 ISSUE cycle then RESP (io_ready 2 cycles after strobe).
//    Read: ISSUE+WAIT total RD_LAT cycles, fp_rd_data sampled on last; io_ready at strobe+RD_LAT+1.
//  USE_RDY: stay ISSUE/WAIT until fp_ready=1 (sampled from first ISSUE cycle), sample fp_rd_data then.
//    Counter reaches TIMEOUT first: drop request, RESP with data 32'hDEAD_BEEF, err_timeout<=1.
//    fp_ready and timeout same cycle: fp_ready wins, no error.
//  RESP: io_ready=1 exactly one cycle, fp_* deasserted, io_read_data=sampled data (0 for writes).
//  Strobe in any state but IDLE: ignored, err_overrun<=1. RESP->IDLE, next strobe accepted the cycle after RESP.
//  err_clr: clears flags next edge; a set event in the same cycle wins (flag stays 1).
//  busy = (state!=IDLE).
// TESTING
//  Reset mid-read (USE_RDY=1, in WAIT) -> next cycle all outputs 0, IDLE; next access completes normally.
//  Write 0xc000_0010, data 0x1234_5678, be 4'hF -> fp_cs=2'b01, fp_addr=4, fp_wr 1 cycle, io_ready @+2.
//  Read 0xc080_0008, RD_LAT=3, slave data 0xA5A5_0001 -> fp_cs=2'b10, fp_addr=2, io_ready @+4 with data.
//  Read 0x4000_0000 -> no fp_cs, io_ready @+1, data 0, err_unmapped=1; err_clr -> 0.
//  USE_RDY=1, fp_ready never -> io_ready after 16 cycles, data 0xDEAD_BEEF, err_timeout=1;
//    fp_ready@+5 -> no error.
//  Strobe during WAIT -> ignored, err_overrun=1, first access still completes once.

Source files
------------

// File: rtl/mcs_bridge_seq.sv
// Registered MCS I/O bus to FPro bridge: decodes the window, issues one access at a time and returns
// io_ready after a fixed read latency or a fp_ready handshake with timeout; sticky error flags.
module mcs_bridge_seq #(
  parameter logic [31:0] BRG_BASE = 32'hc000_0000,
  parameter int          N_CS     = 2,
  parameter int          ADDR_W   = 21,
  parameter int          RD_LAT   = 1,
  parameter int          USE_RDY  = 0,
  parameter int          TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       io_address,
  input  logic              io_addr_strobe,
  input  logic [31:0]       io_write_data,
  input  logic              io_write_strobe,
  input  logic [3:0]        io_byte_enable,
  input  logic              io_read_strobe,
  output logic [31:0]       io_read_data,
  output logic              io_ready,
  output logic [N_CS-1:0]   fp_cs,
  output logic              fp_wr,
  output logic              fp_rd,
  output logic [ADDR_W-1:0] fp_addr,
  output logic [31:0]       fp_wr_data,
  output logic [3:0]        fp_be,
  input  logic [31:0]       fp_rd_data,
  input  logic              fp_ready,
  input  logic              err_clr,
  output logic              err_unmapped,
  output logic              err_timeout,
  output logic              err_overrun,
  output logic              busy
);
  localparam int CS_W = (N_CS > 1) ? $clog2(N_CS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic [7:0]      cnt;
  logic [CS_W-1:0] idx;
  logic            in_window;
  logic            idx_ok;
  logic            one_dir;
  logic            accept;
  logic            done;
  logic [N_CS-1:0] cs_dec;
  logic            unused_addr_lsb;

  assign idx             = io_address[23 -: CS_W];
  assign in_window       = (io_address[31:24] == BRG_BASE[31:24]);
  assign idx_ok          = (32'(idx) < 32'(N_CS));
  assign one_dir         = io_write_strobe ^ io_read_strobe;
  assign accept          = in_window && idx_ok && one_dir;
  assign unused_addr_lsb = ^io_address[1:0];
  assign busy            = (state != IDLE);

  always_comb begin
    cs_dec = '0;
    for (int i = 0; i < N_CS; i++) begin
      cs_dec[i] = (32'(idx) == 32'(i));
    end
  end

  // cnt numbers the request cycles from 1; a fixed-mode write always finishes after its ISSUE cycle.
  assign done = (USE_RDY != 0) ? (fp_ready || (cnt == 8'(TIMEOUT)))
                               : (fp_wr || (cnt == 8'(RD_LAT)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      io_read_data <= '0;
      io_ready     <= 1'b0;
      fp_cs        <= '0;
      fp_wr        <= 1'b0;
      fp_rd        <= 1'b0;
      fp_addr      <= '0;
      fp_wr_data   <= '0;
      fp_be        <= '0;
      err_unmapped <= 1'b0;
      err_timeout  <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      if (err_clr) begin
        err_unmapped <= 1'b0;
        err_timeout  <= 1'b0;
        err_overrun  <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (io_addr_strobe) begin
            fp_addr    <= io_address[ADDR_W+1:2];
            fp_wr_data <= io_write_data;
            fp_be      <= io_byte_enable;
            if (accept) begin
              state <= ISSUE;
              cnt   <= 8'd1;
              fp_cs <= cs_dec;
              fp_wr <= io_write_strobe;
              fp_rd <= io_read_strobe;
            end else begin
              state        <= RESP;
              io_ready     <= 1'b1;
              io_read_data <= '0;
              err_unmapped <= 1'b1;
            end
          end
        end
        ISSUE, WAIT: begin
          if (done) begin
            state    <= RESP;
            io_ready <= 1'b1;
            fp_cs    <= '0;
            fp_wr    <= 1'b0;
            fp_rd    <= 1'b0;
            // A late fp_ready on the timeout cycle still counts as a normal completion.
            if ((USE_RDY != 0) && !fp_ready) begin
              io_read_data <= 32'hDEAD_BEEF;
              err_timeout  <= 1'b1;
            end else begin
              io_read_data <= fp_rd ? fp_rd_data : 32'h0;
            end
          end else begin
            state <= WAIT;
            cnt   <= cnt + 8'd1;
          end
        end
        default: begin
          state    <= IDLE;
          io_ready <= 1'b0;
        end
      endcase
      if (io_addr_strobe && (state != IDLE)) begin
        err_overrun <= 1'b1;
      end
    end
  end

endmodule
